// File: rtl/electric_kettle_ctrl_if.sv
// Sensor/button and power-stage signals of the kettle controller.
// master = the side that drives the sensors (bench/board), slave = the controller.
interface electric_kettle_ctrl_if;
    logic       start_button;
    logic [7:0] temperature_sensor;
    logic       water_level_sensor;
    logic       heater;
    logic       indicator;
    logic       shutdown;

    modport master (
        output start_button,
        output temperature_sensor,
        output water_level_sensor,
        input  heater,
        input  indicator,
        input  shutdown
    );

    modport slave (
        input  start_button,
        input  temperature_sensor,
        input  water_level_sensor,
        output heater,
        output indicator,
        output shutdown
    );
endinterface

// File: rtl/electric_kettle_ctrl.sv
// Moore FSM for an electric kettle: heats on start, lights a lamp when boiled,
// and latches over-temperature / heat-timeout faults until cleared when cool.
module electric_kettle_ctrl #(
    parameter logic [7:0] BOIL_TEMP    = 8'd100,
    parameter logic [7:0] OVER_TEMP    = 8'd150,
    parameter logic [7:0] SAFE_TEMP    = 8'd60,
    parameter int         HEAT_TIMEOUT = 1000,
    parameter int         DONE_HOLD    = 16
) (
    input logic                  clk,
    input logic                  rst,
    electric_kettle_ctrl_if.slave kif
);

    localparam int HT_W = (HEAT_TIMEOUT > 1) ? $clog2(HEAT_TIMEOUT) : 1;
    localparam int DH_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
    localparam logic [HT_W-1:0] HEAT_LAST = HT_W'(HEAT_TIMEOUT - 1);
    localparam logic [DH_W-1:0] HOLD_LAST = DH_W'(DONE_HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READY   = 3'd1,
        ST_HEATING = 3'd2,
        ST_DONE    = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [HT_W-1:0] heat_tmr_q, heat_tmr_d;
    logic [DH_W-1:0] hold_tmr_q, hold_tmr_d;

    logic       start;
    logic       water;
    logic [7:0] temp;

    assign start = kif.start_button;
    assign water = kif.water_level_sensor;
    assign temp  = kif.temperature_sensor;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            heat_tmr_q <= '0;
            hold_tmr_q <= '0;
        end else begin
            state_q    <= state_d;
            heat_tmr_q <= heat_tmr_d;
            hold_tmr_q <= hold_tmr_d;
        end
    end

    // Timers fall back to zero unless the FSM stays put, so every entry starts from 0.
    always_comb begin
        state_d    = state_q;
        heat_tmr_d = '0;
        hold_tmr_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (water) state_d = ST_READY;
            end
            ST_READY: begin
                if (!water)     state_d = ST_IDLE;
                else if (start) state_d = ST_HEATING;
            end
            ST_HEATING: begin
                if (temp >= OVER_TEMP)           state_d = ST_FAULT;
                else if (!water)                 state_d = ST_IDLE;
                else if (temp >= BOIL_TEMP)      state_d = ST_DONE;
                else if (heat_tmr_q == HEAT_LAST) state_d = ST_FAULT;
                else if (heat_tmr_q == '1)       heat_tmr_d = heat_tmr_q;
                else                             heat_tmr_d = heat_tmr_q + HT_W'(1);
            end
            ST_DONE: begin
                if (!water)                       state_d = ST_IDLE;
                else if (hold_tmr_q == HOLD_LAST) state_d = ST_READY;
                else if (hold_tmr_q == '1)        hold_tmr_d = hold_tmr_q;
                else                              hold_tmr_d = hold_tmr_q + DH_W'(1);
            end
            ST_FAULT: begin
                if (start && (temp < SAFE_TEMP)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        kif.heater    = 1'b0;
        kif.indicator = 1'b0;
        kif.shutdown  = 1'b0;
        case (state_q)
            ST_HEATING: kif.heater    = 1'b1;
            ST_DONE:    kif.indicator = 1'b1;
            ST_FAULT:   kif.shutdown  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_electric_kettle_ctrl.sv
// Randomised and directed bench for electric_kettle_ctrl against a mode/age reference model.
module tb_electric_kettle_ctrl;

    localparam int HEAT_TO = 8;
    localparam int HOLD    = 16;

    localparam int M_IDLE    = 0;
    localparam int M_READY   = 1;
    localparam int M_HEATING = 2;
    localparam int M_DONE    = 3;
    localparam int M_FAULT   = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    electric_kettle_ctrl_if kif ();

    electric_kettle_ctrl #(
        .BOIL_TEMP    (8'd100),
        .OVER_TEMP    (8'd150),
        .SAFE_TEMP    (8'd60),
        .HEAT_TIMEOUT (HEAT_TO),
        .DONE_HOLD    (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: which mode the kettle is in and how many cycles it has been there.
    int m_mode = M_IDLE;
    int m_age  = 0;

    function automatic int next_mode(input int mode, input int age,
                                     input logic s, input int t, input logic w);
        int n;
        n = mode;
        if (mode == M_IDLE) begin
            if (w) n = M_READY;
        end else if (mode == M_READY) begin
            if (!w) n = M_IDLE;
            else if (s) n = M_HEATING;
        end else if (mode == M_HEATING) begin
            if (t >= 150) n = M_FAULT;
            else if (!w) n = M_IDLE;
            else if (t >= 100) n = M_DONE;
            else if (age + 1 >= HEAT_TO) n = M_FAULT;
        end else if (mode == M_DONE) begin
            if (!w) n = M_IDLE;
            else if (age + 1 >= HOLD) n = M_READY;
        end else begin
            if (s && t < 60) n = M_IDLE;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode <= M_IDLE;
            m_age  <= 0;
        end else begin
            m_mode <= next_mode(m_mode, m_age, kif.start_button,
                                int'(kif.temperature_sensor), kif.water_level_sensor);
            m_age  <= (next_mode(m_mode, m_age, kif.start_button,
                                 int'(kif.temperature_sensor), kif.water_level_sensor) != m_mode)
                      ? 0 : m_age + 1;
        end
    end

    always @(negedge clk) begin
        chk("model_heater",    int'(kif.heater),    int'(m_mode == M_HEATING));
        chk("model_indicator", int'(kif.indicator), int'(m_mode == M_DONE));
        chk("model_shutdown",  int'(kif.shutdown),  int'(m_mode == M_FAULT));
    end

    task automatic tick(input logic s, input int t, input logic w);
        kif.start_button       = s;
        kif.temperature_sensor = 8'(t);
        kif.water_level_sensor = w;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    function automatic int pick_temp();
        int r;
        r = int'($urandom_range(0, 9));
        case (r)
            0: return 59;
            1: return 60;
            2: return 99;
            3: return 100;
            4: return 149;
            5: return 150;
            6: return int'($urandom_range(0, 255));
            default: return int'($urandom_range(10, 95));
        endcase
    endfunction

    initial begin
        int lit;
        int hot;
        errors = 0;
        checks = 0;
        rst = 1'b0;
        kif.start_button       = 1'b1;
        kif.temperature_sensor = 8'd200;
        kif.water_level_sensor = 1'b1;

        // Reset holds everything off whatever the inputs say.
        tick(1'b1, 200, 1'b1);
        chk("rst_heater",    int'(kif.heater),    0);
        chk("rst_indicator", int'(kif.indicator), 0);
        chk("rst_shutdown",  int'(kif.shutdown),  0);
        rst = 1'b1;

        // Normal boil.
        tick(1'b0, 50, 1'b1);
        tick(1'b1, 50, 1'b1);
        chk("boil_heater_on", int'(kif.heater), 1);
        tick(1'b0, 100, 1'b1);
        chk("boil_heater_off", int'(kif.heater), 0);
        chk("boil_lamp_on",    int'(kif.indicator), 1);
        lit = 1;
        repeat (20) begin
            tick(1'b1, 100, 1'b1);
            if (kif.indicator) lit++;
            if (kif.heater) break;
        end
        chk("boil_lamp_cycles", lit, HOLD);
        chk("boil_lamp_off",    int'(kif.indicator), 0);

        // Water loss while heating.
        tick(1'b0, 50, 1'b1);
        tick(1'b1, 50, 1'b1);
        tick(1'b0, 50, 1'b0);
        chk("dry_heater",   int'(kif.heater),    0);
        chk("dry_shutdown", int'(kif.shutdown),  0);
        chk("dry_lamp",     int'(kif.indicator), 0);
        tick(1'b1, 50, 1'b0);
        chk("dry_start_ignored", int'(kif.heater), 0);

        // Over-temperature fault and clearing.
        tick(1'b0, 50, 1'b1);
        tick(1'b1, 50, 1'b1);
        tick(1'b0, 150, 1'b1);
        chk("ovt_shutdown", int'(kif.shutdown), 1);
        chk("ovt_heater",   int'(kif.heater),   0);
        tick(1'b1, 100, 1'b0);
        chk("ovt_hot_clear", int'(kif.shutdown), 1);
        tick(1'b1, 60, 1'b1);
        chk("ovt_safe_edge", int'(kif.shutdown), 1);
        tick(1'b1, 59, 1'b0);
        chk("ovt_cleared", int'(kif.shutdown), 0);

        // Heat timeout.
        tick(1'b0, 30, 1'b1);
        tick(1'b1, 30, 1'b1);
        hot = 1;
        repeat (12) begin
            tick(1'b0, 30, 1'b1);
            if (kif.heater) hot++;
        end
        chk("to_heat_cycles", hot, HEAT_TO);
        chk("to_shutdown",    int'(kif.shutdown), 1);
        tick(1'b1, 10, 1'b1);

        // Simultaneous events.
        tick(1'b0, 30, 1'b1);
        tick(1'b1, 30, 1'b1);
        tick(1'b0, 200, 1'b0);
        chk("sim_fault_wins", int'(kif.shutdown), 1);
        tick(1'b1, 0, 1'b0);
        tick(1'b0, 30, 1'b1);
        tick(1'b1, 30, 1'b1);
        tick(1'b0, 100, 1'b0);
        chk("sim_idle_lamp",   int'(kif.indicator), 0);
        chk("sim_idle_heater", int'(kif.heater),    0);

        // Random traffic, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                tick(1'($urandom_range(0, 1)), pick_temp(), 1'($urandom_range(0, 1)));
                rst = 1'b1;
            end else begin
                tick(1'($urandom_range(0, 2) == 0), pick_temp(),
                     1'($urandom_range(0, 15) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
